// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_skid_buf.sv
// One-entry holding register for a fetched pc/instruction that arrived
// while the IF/ID slot was still occupied.
module fetch_skid_buf
  import if_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       flush_i,
  input  fetch_pkt_t pkt_i,
  output logic       valid_o,
  output fetch_pkt_t pkt_o
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  // Flush beats load beats unload.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding and
// presents pc / pc+4 / instruction to the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSN = DEF_NOP_INSN
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        if_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_now_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_infl_q;
  logic         kill_q;
  logic         if_valid_q;
  logic [31:0]  if_now_pc_q;
  logic [31:0]  if_pc_plus_4_q;
  logic [31:0]  if_instruction_q;

  logic         slot_free_s;
  logic         accept_s;
  logic         redir_s;
  logic         rsp_live_s;
  logic         skid_valid_s;
  fetch_pkt_t   skid_in_s;
  fetch_pkt_t   skid_out_s;

  assign slot_free_s = !if_valid_q || !if_stall;
  assign redir_s     = redirect_valid && (state_q != ST_IDLE);
  assign imem_req    = (state_q == ST_REQ) && !kill_q && (slot_free_s || !skid_valid_s);
  assign imem_addr   = pc_q;
  assign accept_s    = imem_req && imem_ready;
  assign rsp_live_s  = (state_q == ST_WAIT) && imem_rvalid && !kill_q;
  assign skid_in_s   = '{pc: pc_infl_q, insn: imem_rdata};

  fetch_skid_buf u_skid (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst),
    .load_i   (!redir_s && rsp_live_s && !slot_free_s),
    .unload_i (!redir_s && (state_q == ST_FULL) && slot_free_s),
    .flush_i  (redir_s),
    .pkt_i    (skid_in_s),
    .valid_o  (skid_valid_s),
    .pkt_o    (skid_out_s)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q          <= ST_IDLE;
      pc_q             <= RESET_PC;
      pc_infl_q        <= RESET_PC;
      kill_q           <= 1'b0;
      if_valid_q       <= 1'b0;
      if_now_pc_q      <= 32'h0000_0000;
      if_pc_plus_4_q   <= 32'h0000_0000;
      if_instruction_q <= NOP_INSN;
    end else if (redir_s) begin
      // A redirect outranks stall; an accepted or still-pending request must be killed.
      if_valid_q       <= 1'b0;
      if_instruction_q <= NOP_INSN;
      pc_q             <= word_align(redirect_pc);
      if (accept_s || ((state_q == ST_WAIT) && !imem_rvalid)) begin
        state_q <= ST_WAIT;
        kill_q  <= 1'b1;
      end else begin
        state_q <= ST_REQ;
        kill_q  <= 1'b0;
      end
    end else begin
      if (slot_free_s) begin
        if_valid_q       <= 1'b0;
        if_instruction_q <= NOP_INSN;
      end
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (accept_s) begin
            state_q   <= ST_WAIT;
            pc_infl_q <= pc_q;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= ST_REQ;
            end else begin
              pc_q <= pc_infl_q + 32'd4;
              if (slot_free_s) begin
                if_valid_q       <= 1'b1;
                if_now_pc_q      <= pc_infl_q;
                if_pc_plus_4_q   <= pc_infl_q + 32'd4;
                if_instruction_q <= imem_rdata;
                state_q          <= ST_REQ;
              end else begin
                state_q <= ST_FULL;
              end
            end
          end
        end
        ST_FULL: begin
          if (slot_free_s) begin
            if_valid_q       <= 1'b1;
            if_now_pc_q      <= skid_out_s.pc;
            if_pc_plus_4_q   <= skid_out_s.pc + 32'd4;
            if_instruction_q <= skid_out_s.insn;
            state_q          <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_valid       = if_valid_q;
  assign if_now_pc      = if_now_pc_q;
  assign if_pc_plus_4   = if_pc_plus_4_q;
  assign if_instruction = if_instruction_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch with a behavioural instruction memory.
module tb_if_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        if_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_now_pc, if_pc_plus_4, if_instruction;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2 = 32'h0;
  logic        if_valid2;
  logic [31:0] if_now_pc2, if_pc_plus_42, if_instruction2;

  always #5 sys_clk = ~sys_clk;

  if_fetch dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .if_stall(if_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_now_pc(if_now_pc), .if_pc_plus_4(if_pc_plus_4),
    .if_instruction(if_instruction)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .if_stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(1'b1),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .if_valid(if_valid2), .if_now_pc(if_now_pc2), .if_pc_plus_4(if_pc_plus_42),
    .if_instruction(if_instruction2)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          mem_lat = 0;
  logic [31:0] exp_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, req);
  endtask

  // Memory model + monitor: all sampling at negedge, memory drives #1 after posedge.
  initial begin : env
    logic redir, acc_f, acc_stale, pend, pend_stale, cur_stale, hold_f;
    logic [31:0] acc_addr, pend_addr, cur_addr, h_pc, h_pc4, h_insn;
    int pend_cnt;
    exp_t e;
    pend = 1'b0; pend_stale = 1'b0; cur_stale = 1'b0; hold_f = 1'b0;
    pend_cnt = 0; pend_addr = 32'h0; cur_addr = 32'h0;
    h_pc = 32'h0; h_pc4 = 32'h0; h_insn = 32'h0;
    forever begin
      @(negedge sys_clk);
      redir = redirect_valid || !sys_rst;
      if (sys_rst) begin
        if (hold_f) begin
          chk("hold_pc", if_now_pc, h_pc);
          chk("hold_pc4", if_pc_plus_4, h_pc4);
          chk("hold_insn", if_instruction, h_insn);
        end
        if (if_valid && !if_stall) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_out", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            chk("out_pc", if_now_pc, e.pc);
            chk("out_pc4", if_pc_plus_4, e.pc + 32'd4);
            chk("out_insn", if_instruction, e.insn);
          end
        end
        if (imem_req && imem_ready) chk("req_addr", imem_addr, exp_addr);
      end
      hold_f = sys_rst && if_valid && if_stall && !redirect_valid;
      h_pc = if_now_pc; h_pc4 = if_pc_plus_4; h_insn = if_instruction;
      if (imem_rvalid && !redir && !cur_stale) begin
        sb_q.push_back('{pc: cur_addr, insn: cur_addr ^ 32'h0000_A5A5});
        exp_addr = cur_addr + 32'd4;
      end
      if (redir) begin
        sb_q.delete();
        exp_addr = sys_rst ? (redirect_pc & ~32'd3) : 32'h0000_0000;
        pend_stale = 1'b1;
      end
      acc_f = imem_req && imem_ready;
      acc_addr = imem_addr;
      acc_stale = redir;
      @(posedge sys_clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc_f) begin
        pend = 1'b1; pend_addr = acc_addr; pend_cnt = mem_lat; pend_stale = acc_stale;
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = pend_addr ^ 32'h0000_A5A5;
          cur_addr = pend_addr;
          cur_stale = pend_stale;
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  // Single-cycle memory for the wrap-around instance; captures its first two outputs.
  logic [31:0] cap_pc[2], cap_pc4[2], cap_insn[2];
  int n2 = 0;
  initial begin : env2
    logic a2;
    logic [31:0] ad2;
    forever begin
      @(negedge sys_clk);
      if (sys_rst && if_valid2 && n2 < 2) begin
        cap_pc[n2] = if_now_pc2; cap_pc4[n2] = if_pc_plus_42; cap_insn[n2] = if_instruction2;
        n2++;
      end
      a2 = imem_req2;
      ad2 = imem_addr2;
      @(posedge sys_clk);
      #1;
      imem_rvalid2 = a2;
      imem_rdata2 = ad2 ^ 32'h0000_A5A5;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge sys_clk);
      if (if_valid === 1'b1) break;
    end
    chk(tag, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic wait_accept(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge sys_clk);
      if ((imem_req && imem_ready) === 1'b1) break;
    end
    chk(tag, {31'd0, imem_req && imem_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin : main
    cyc(3);
    @(negedge sys_clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_now_pc, 32'h0);
    chk("rst_pc4", if_pc_plus_4, 32'h0);
    chk("rst_insn", if_instruction, 32'h0000_0013);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    imem_ready = 1'b1;

    wait_valid("first_wait", 20);
    chk("first_pc", if_now_pc, 32'h0);
    chk("first_pc4", if_pc_plus_4, 32'h4);
    chk("first_insn", if_instruction, 32'h0000_A5A5);
    cyc(20);

    if_stall = 1'b1; cyc(3); if_stall = 1'b0; cyc(8);
    for (int i = 0; i < 30; i++) begin
      if_stall = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    if_stall = 1'b0; cyc(4);

    // Redirect while a slow response is outstanding.
    mem_lat = 3;
    wait_accept("rw_accept", 20);
    @(posedge sys_clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cyc(1);
    redirect_valid = 1'b0;
    wait_valid("rw_wait", 30);
    chk("rw_pc", if_now_pc, 32'h0000_0100);
    mem_lat = 0;
    cyc(4);

    // Redirect coinciding with the response.
    wait_accept("rv_accept", 20);
    @(posedge sys_clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc(1);
    redirect_valid = 1'b0;
    wait_accept("rv_next", 10);
    chk("rv_addr", imem_addr, 32'h0000_0200);
    cyc(6);

    for (int i = 0; i < 60; i++) begin
      if_stall = ($urandom_range(0, 3) == 0);
      mem_lat = $urandom_range(0, 2);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                 : $urandom;
      cyc(1);
    end
    redirect_valid = 1'b0; if_stall = 1'b0; mem_lat = 0;
    cyc(6);

    imem_ready = 1'b0;
    cyc(4);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("nrdy_req", {31'd0, imem_req}, 32'd1);
      chk("nrdy_addr", imem_addr, exp_addr);
      chk("nrdy_valid", {31'd0, if_valid}, 32'd0);
    end

    chk("wrap_count", 32'(n2), 32'd2);
    chk("wrap_pc0", cap_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc4_0", cap_pc4[0], 32'h0);
    chk("wrap_insn0", cap_insn[0], 32'hFFFF_5A59);
    chk("wrap_pc1", cap_pc[1], 32'h0);
    chk("wrap_pc4_1", cap_pc4[1], 32'h4);

    // Reset while a slow response is in flight; it lands after release.
    @(posedge sys_clk); #1;
    imem_ready = 1'b1; mem_lat = 4;
    wait_accept("rst_accept", 20);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; imem_ready = 1'b0;
    cyc(2);
    sys_rst = 1'b1;
    cyc(8);
    mem_lat = 0; imem_ready = 1'b1;
    wait_valid("rst_wait", 20);
    chk("rst_restart_pc", if_now_pc, 32'h0);
    chk("rst_restart_insn", if_instruction, 32'h0000_A5A5);
    cyc(10);

    imem_ready = 1'b0;
    cyc(6);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
